// File: rtl/int_to_fp16.sv
// Signed fixed-point to IEEE-754 binary16 encoder: one normalising shift per cycle,
// round-to-nearest-even, and adder-style status flags on a valid/ready output.
//
// state | meaning
// IDLE  | ready for a new operand
// NORM  | shifting magnitude left until its MSB is set (or it is zero)
// ROUND | rounding and packing the fp16 word
// HOLD  | result presented, waiting for o_out_ready
module int_to_fp16 #(
   parameter int IN_W   = 24,
   parameter int FRAC_W = 0
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [IN_W-1:0] i_in_data,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [15:0]     o_result,
   output logic            o_overflow,
   output logic            o_zero,
   output logic            o_precision_lost
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

   // Exponent for lz = 0, before the rounding carry: IN_W-1-FRAC_W+15.
   localparam int EXP_BASE = IN_W + 14 - FRAC_W;

   state_t          r_state;
   logic            r_sign;
   logic [IN_W-1:0] r_mag;
   logic [5:0]      r_lz;
   logic [15:0]     r_result;
   logic            r_overflow;
   logic            r_zero;
   logic            r_precision_lost;
   logic            r_out_valid;

   logic [IN_W-1:0] w_abs;
   logic [9:0]      w_frac;
   logic            w_guard;
   logic            w_sticky;
   logic            w_round_up;
   logic [10:0]     w_frac_inc;
   logic            w_carry;
   logic [9:0]      w_frac_out;
   logic [6:0]      w_exp;
   logic            w_mag_zero;

   // Negating -2^(IN_W-1) yields the same bit pattern, which is its exact magnitude.
   assign w_abs      = i_in_data[IN_W-1] ? -i_in_data : i_in_data;

   assign w_mag_zero = (r_mag == '0);
   assign w_frac     = r_mag[IN_W-2 -: 10];
   assign w_guard    = r_mag[IN_W-12];
   assign w_sticky   = |r_mag[IN_W-13:0];
   assign w_round_up = w_guard & (w_sticky | w_frac[0]);
   assign w_frac_inc = {1'b0, w_frac} + 11'd1;
   assign w_carry    = w_round_up & w_frac_inc[10];
   assign w_frac_out = w_round_up ? w_frac_inc[9:0] : w_frac;
   assign w_exp      = 7'(EXP_BASE) - {1'b0, r_lz} + {6'd0, w_carry};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state          <= IDLE;
         r_sign           <= 1'b0;
         r_mag            <= '0;
         r_lz             <= '0;
         r_result         <= 16'h0000;
         r_overflow       <= 1'b0;
         r_zero           <= 1'b0;
         r_precision_lost <= 1'b0;
         r_out_valid      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_in_valid) begin
                  r_sign  <= i_in_data[IN_W-1];
                  r_mag   <= w_abs;
                  r_lz    <= '0;
                  r_state <= NORM;
               end
            end
            NORM: begin
               if (w_mag_zero || r_mag[IN_W-1]) begin
                  r_state <= ROUND;
               end else begin
                  r_mag <= r_mag << 1;
                  r_lz  <= r_lz + 6'd1;
               end
            end
            ROUND: begin
               r_state     <= HOLD;
               r_out_valid <= 1'b1;
               if (w_mag_zero) begin
                  r_result         <= 16'h0000;
                  r_zero           <= 1'b1;
                  r_overflow       <= 1'b0;
                  r_precision_lost <= 1'b0;
               end else if (w_exp >= 7'd31) begin
                  r_result         <= {r_sign, 5'h1F, 10'h000};
                  r_zero           <= 1'b0;
                  r_overflow       <= 1'b1;
                  r_precision_lost <= 1'b1;
               end else begin
                  r_result         <= {r_sign, w_exp[4:0], w_frac_out};
                  r_zero           <= 1'b0;
                  r_overflow       <= 1'b0;
                  r_precision_lost <= w_guard | w_sticky;
               end
            end
            HOLD: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready       = (r_state == IDLE);
   assign o_out_valid      = r_out_valid;
   assign o_result         = r_result;
   assign o_overflow       = r_overflow;
   assign o_zero           = r_zero;
   assign o_precision_lost = r_precision_lost;

endmodule

// File: tb/tb_int_to_fp16.sv
// Scoreboard bench for int_to_fp16: two instances (FRAC_W = 0 and FRAC_W = 8),
// expected words pushed at issue time and popped by per-instance output monitors.
module tb_int_to_fp16;

   logic        clk;
   logic        rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [23:0] a_in_data;
   logic [15:0] a_result;
   logic        a_ovf, a_zero, a_pl;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [23:0] b_in_data;
   logic [15:0] b_result;
   logic        b_ovf, b_zero, b_pl;

   int n_vec  = 0;
   int n_miss = 0;

   logic [18:0] q_a[$];
   logic [18:0] q_b[$];

   int_to_fp16 #(.IN_W(24), .FRAC_W(0)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
      .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_result(a_result),
      .o_overflow(a_ovf), .o_zero(a_zero), .o_precision_lost(a_pl)
   );

   int_to_fp16 #(.IN_W(24), .FRAC_W(8)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
      .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_result(b_result),
      .o_overflow(b_ovf), .o_zero(b_zero), .o_precision_lost(b_pl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Output monitors: a handshake at the coming edge retires one scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_output", {13'd0, a_result, a_ovf, a_zero, a_pl}, 32'hFFFF_FFFF);
         end else begin
            check("a_result_flags", {13'd0, a_result, a_ovf, a_zero, a_pl}, {13'd0, q_a.pop_front()});
         end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_output", {13'd0, b_result, b_ovf, b_zero, b_pl}, 32'hFFFF_FFFF);
         end else begin
            check("b_result_flags", {13'd0, b_result, b_ovf, b_zero, b_pl}, {13'd0, q_b.pop_front()});
         end
      end
   end

   // Issue one operand to instance A and check the accept-to-out_valid latency.
   task automatic send_a(input logic [23:0] d, input logic [15:0] r, input logic ov,
                         input logic z, input logic pl, input int lat);
      int w;
      int cnt;
      q_a.push_back({r, ov, z, pl});
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = d;
      w = 0;
      while (!a_in_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (w >= 60) check("a_accept_timeout", 32'(w), 32'd0);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      a_in_data  = ~d;
      cnt = 0;
      do begin
         @(posedge clk);
         cnt++;
         #1;
      end while (!a_out_valid && cnt < 40);
      check("a_latency", 32'(cnt), 32'(lat));
      @(posedge clk);
      #1;
   endtask

   task automatic send_b(input logic [23:0] d, input logic [15:0] r, input logic ov,
                         input logic z, input logic pl);
      int cnt;
      q_b.push_back({r, ov, z, pl});
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = d;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_in_data  = '0;
      cnt = 0;
      while (!b_out_valid && cnt < 40) begin
         @(posedge clk);
         cnt++;
         #1;
      end
      if (cnt >= 40) check("b_output_timeout", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      rst_n       = 1'b0;
      a_in_valid  = 1'b0;
      a_in_data   = '0;
      a_out_ready = 1'b1;
      b_in_data   = 24'h000180;
      b_in_valid  = 1'b1;
      b_out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", {31'd0, a_in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
      check("reset_outputs", {13'd0, a_result, a_ovf, a_zero, a_pl}, 32'd0);
      check("reset_b_not_accepted", {31'd0, b_in_ready}, 32'd1);

      // B's in_valid was held through reset: the first accept is the first edge after release.
      q_b.push_back({16'h3E00, 3'b000});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      check("b_accept_after_reset", {31'd0, b_in_ready}, 32'd0);

      send_a(24'd1,        16'h3C00, 1'b0, 1'b0, 1'b0, 25);
      send_a(-24'sd3,      16'hC200, 1'b0, 1'b0, 1'b0, 24);
      send_a(24'd0,        16'h0000, 1'b0, 1'b1, 1'b0, 2);
      send_a(24'd65504,    16'h7BFF, 1'b0, 1'b0, 1'b0, 10);
      send_a(24'd2049,     16'h6800, 1'b0, 1'b0, 1'b1, 14);
      send_a(24'd2051,     16'h6802, 1'b0, 1'b0, 1'b1, 14);
      send_a(24'd2050,     16'h6801, 1'b0, 1'b0, 1'b0, 14);
      send_a(24'd65520,    16'h7C00, 1'b1, 1'b0, 1'b1, 10);
      send_a(24'h800000,   16'hFC00, 1'b1, 1'b0, 1'b1, 2);

      send_b(24'hFFFFFF,   16'h9C00, 1'b0, 1'b0, 1'b0);

      // Backpressure: result must hold while out_ready is low.
      a_out_ready = 1'b0;
      q_a.push_back({16'h6800, 3'b001});
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 24'd2049;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      cnt = 0;
      while (!a_out_valid && cnt < 40) begin
         @(posedge clk);
         cnt++;
         #1;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", {31'd0, a_out_valid}, 32'd1);
         check("bp_hold_result", {13'd0, a_result, a_ovf, a_zero, a_pl}, {13'd0, 16'h6800, 3'b001});
         check("bp_in_ready_low", {31'd0, a_in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      a_out_ready = 1'b1;
      @(posedge clk);
      #1;
      a_out_ready = 1'b0;
      check("bp_valid_dropped", {31'd0, a_out_valid}, 32'd0);
      check("bp_in_ready_back", {31'd0, a_in_ready}, 32'd1);
      a_out_ready = 1'b1;
      send_a(24'd2051,     16'h6802, 1'b0, 1'b0, 1'b1, 14);

      // Reset mid-conversion: the partial result must never appear.
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 24'd1;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", {31'd0, a_out_valid}, 32'd0);
      check("rst_mid_result", {13'd0, a_result, a_ovf, a_zero, a_pl}, 32'd0);
      check("rst_mid_in_ready", {31'd0, a_in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_a(24'h7FFFFF,   16'h7C00, 1'b1, 1'b0, 1'b1, 3);

      repeat (30) @(posedge clk);
      #1;
      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
